// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_pkg
//  Description : Shared types and constants for the two-port memory/MMIO
//                bus arbiter (access sizes, region decode, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HWORD = 2'd1,
    SIZE_WORD  = 2'd2
  } mem_size_t;

  // Default MMIO window: any address whose bits [11:8] equal 4'h1.
  localparam logic [31:0] MMIO_BASE_ADDR = 32'h0000_0100;
  localparam logic [31:0] MMIO_ADDR_MASK = 32'h0000_0F00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    mem_size_t   size;
  } bus_req_t;

  // Only the two low address bits matter for alignment.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HWORD: is_misaligned = addr_lo[0];
      SIZE_WORD:  is_misaligned = |addr_lo;
      default:    is_misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Request/response and memory-side bus bundle of the arbiter.
//                Signal directions in the names are from the arbiter's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  // requester side
  logic [1:0]        i_req_valid;
  logic [1:0]        o_req_ready;
  logic [1:0]        i_req_we;
  logic [1:0][31:0]  i_req_addr;
  logic [1:0][31:0]  i_req_wdata;
  mem_size_t         i_req_size [2];
  logic [1:0]        o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;

  // memory / MMIO side
  logic [31:0]       o_bus_addr;
  logic [31:0]       o_bus_wdata;
  mem_size_t         o_bus_size;
  logic              o_mem_we;
  logic              o_mem_re;
  logic              o_mmio_we;
  logic              o_mmio_re;
  logic [31:0]       i_bus_rdata;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_bus_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_bus_addr, o_bus_wdata, o_bus_size,
    output o_mem_we, o_mem_re, o_mmio_we, o_mmio_re
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_bus_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_bus_addr, o_bus_wdata, o_bus_size,
    input  o_mem_we, o_mem_re, o_mmio_we, o_mmio_re
  );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin grant. The grant is combinational
//                from valid and the last-grant pointer; the pointer moves to
//                the granted port on every accepted request.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  logic       last_q;
  logic       last_d;
  logic [1:0] grant_raw;

  // Lone requester wins; on a tie the port not served last wins.
  always_comb begin
    grant_raw = 2'b00;
    case (i_valid)
      2'b01:   grant_raw = 2'b01;
      2'b10:   grant_raw = 2'b10;
      2'b11:   grant_raw = last_q ? 2'b01 : 2'b10;
      default: grant_raw = 2'b00;
    endcase
    o_grant = i_enable ? grant_raw : 2'b00;
    last_d  = last_q;
    if (|o_grant) begin
      last_d = o_grant[1];
    end
  end

  // Last-grant pointer; resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Two-port round-robin arbiter/sequencer for the shared data
//                memory / MMIO bus. One transaction at a time: grant, decode
//                into a registered strobe, wait out read latency, respond.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_ADDR,
  parameter logic [31:0] MMIO_MASK  = MMIO_ADDR_MASK
) (
  input  logic             i_clk,
  input  logic             i_rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned     CNT_W     = 3;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LATENCY - 1);

  arb_state_t       state_q, state_d;
  bus_req_t         req_q, req_d;
  logic             port_q, port_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             mem_we_q, mem_we_d;
  logic             mem_re_q, mem_re_d;
  logic             mmio_we_q, mmio_we_d;
  logic             mmio_re_q, mmio_re_d;

  logic             accept_en;
  logic [1:0]       grant;
  logic             hs;
  logic             sel;
  bus_req_t         new_req;
  logic             new_mmio;
  logic             new_misaligned;

  // New requests are only taken while idle or while emitting a response.
  assign accept_en = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && !i_rst;

  rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (bus.i_req_valid),
    .i_enable (accept_en),
    .o_grant  (grant)
  );

  assign hs  = |(grant & bus.i_req_valid);
  assign sel = grant[1];

  // Payload of the granted port plus its region and alignment decode.
  always_comb begin
    new_req.we     = bus.i_req_we[sel];
    new_req.addr   = bus.i_req_addr[sel];
    new_req.wdata  = bus.i_req_wdata[sel];
    new_req.size   = bus.i_req_size[sel];
    new_mmio       = (new_req.addr & MMIO_MASK) == MMIO_BASE;
    new_misaligned = is_misaligned(new_req.size, new_req.addr[1:0]);
  end

  // Sequencer next state; strobes and response are set one edge ahead so
  // that every output leaves a flop.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mmio_we_d   = 1'b0;
    mmio_re_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (hs) begin
          req_d  = new_req;
          port_d = sel;
          if (new_misaligned) begin
            // Rejected without touching the bus.
            state_d     = ST_RESP;
            rsp_valid_d = {sel, ~sel};
            rsp_err_d   = 1'b1;
          end else begin
            state_d   = ST_ACCESS;
            mem_we_d  =  new_req.we && !new_mmio;
            mem_re_d  = !new_req.we && !new_mmio;
            mmio_we_d =  new_req.we &&  new_mmio;
            mmio_re_d = !new_req.we &&  new_mmio;
          end
        end
      end
      ST_ACCESS: begin
        if (req_q.we || (RD_LATENCY <= 1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = {port_q, ~port_q};
          rsp_rdata_d = req_q.we ? 32'h0 : bus.i_bus_rdata;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = {port_q, ~port_q};
          rsp_rdata_d = bus.i_bus_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      port_q      <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mmio_we_q   <= 1'b0;
      mmio_re_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      port_q      <= port_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mmio_we_q   <= mmio_we_d;
      mmio_re_q   <= mmio_re_d;
    end
  end

  assign bus.o_req_ready = grant;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_bus_addr  = req_q.addr;
  assign bus.o_bus_wdata = req_q.wdata;
  assign bus.o_bus_size  = req_q.size;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_re    = mem_re_q;
  assign bus.o_mmio_we   = mmio_we_q;
  assign bus.o_mmio_re   = mmio_re_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Directed self-checking bench for mem_bus_arbiter, with one
//                instance at read latency 1 and one at read latency 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_a();
  mem_bus_arbiter_if bus_b();

  mem_bus_arbiter #(.RD_LATENCY(1), .MMIO_BASE(32'h100), .MMIO_MASK(32'hF00)) u_dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a)
  );

  mem_bus_arbiter #(.RD_LATENCY(3), .MMIO_BASE(32'h100), .MMIO_MASK(32'hF00)) u_dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b)
  );

  // strobe vectors ordered {mem_we, mem_re, mmio_we, mmio_re}
  logic [3:0] strb_a;
  logic [3:0] strb_b;
  assign strb_a = {bus_a.o_mem_we, bus_a.o_mem_re, bus_a.o_mmio_we, bus_a.o_mmio_re};
  assign strb_b = {bus_b.o_mem_we, bus_b.o_mem_re, bus_b.o_mmio_we, bus_b.o_mmio_re};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs change here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;

    bus_a.i_req_valid = 2'b00; bus_a.i_req_we = 2'b00;
    bus_a.i_req_addr = '0; bus_a.i_req_wdata = '0;
    bus_a.i_req_size[0] = SIZE_BYTE; bus_a.i_req_size[1] = SIZE_BYTE;
    bus_a.i_bus_rdata = 32'h0;
    bus_b.i_req_valid = 2'b00; bus_b.i_req_we = 2'b00;
    bus_b.i_req_addr = '0; bus_b.i_req_wdata = '0;
    bus_b.i_req_size[0] = SIZE_BYTE; bus_b.i_req_size[1] = SIZE_BYTE;
    bus_b.i_bus_rdata = 32'h0;

    // ---------------- reset values
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_eq("rst_ready",     32'(bus_a.o_req_ready), 32'h0);
    check_eq("rst_rsp_valid", 32'(bus_a.o_rsp_valid), 32'h0);
    check_eq("rst_rdata",     bus_a.o_rsp_rdata,      32'h0);
    check_eq("rst_err",       32'(bus_a.o_rsp_err),   32'h0);
    check_eq("rst_strobes",   32'(strb_a),            32'h0);
    check_eq("rst_bus_addr",  bus_a.o_bus_addr,       32'h0);
    check_eq("rst_bus_wdata", bus_a.o_bus_wdata,      32'h0);
    check_eq("rst_bus_size",  32'(bus_a.o_bus_size),  32'h0);
    check_eq("rst_b_rsp",     32'(bus_b.o_rsp_valid), 32'h0);

    // ---------------- port 0 WORD read at 0x40, latency 1
    tick();
    bus_a.i_bus_rdata = 32'hDEADBEEF;
    bus_a.i_req_we[0] = 1'b0; bus_a.i_req_addr[0] = 32'h40; bus_a.i_req_size[0] = SIZE_WORD;
    bus_a.i_req_valid = 2'b01;
    #1;
    check_eq("rd_ready", 32'(bus_a.o_req_ready), 32'h1);
    tick(); bus_a.i_req_valid = 2'b00; #1;
    check_eq("rd_strobe",    32'(strb_a),            32'h4);
    check_eq("rd_bus_addr",  bus_a.o_bus_addr,       32'h40);
    check_eq("rd_early_rsp", 32'(bus_a.o_rsp_valid), 32'h0);
    tick(); #1;
    check_eq("rd_rsp_valid", 32'(bus_a.o_rsp_valid), 32'h1);
    check_eq("rd_rdata",     bus_a.o_rsp_rdata,      32'hDEADBEEF);
    check_eq("rd_err",       32'(bus_a.o_rsp_err),   32'h0);
    check_eq("rd_strobe_off", 32'(strb_a),           32'h0);
    tick(); #1;
    check_eq("rd_rsp_pulse", 32'(bus_a.o_rsp_valid), 32'h0);

    // ---------------- port 1 BYTE write 0x5A into the MMIO window (0x104)
    tick();
    bus_a.i_req_we[1] = 1'b1; bus_a.i_req_addr[1] = 32'h104;
    bus_a.i_req_wdata[1] = 32'h5A; bus_a.i_req_size[1] = SIZE_BYTE;
    bus_a.i_req_valid = 2'b10;
    #1;
    check_eq("mmio_wr_ready", 32'(bus_a.o_req_ready), 32'h2);
    tick(); bus_a.i_req_valid = 2'b00; #1;
    check_eq("mmio_wr_strobe", 32'(strb_a),          32'h2);
    check_eq("mmio_wr_wdata",  bus_a.o_bus_wdata,    32'h5A);
    check_eq("mmio_wr_addr",   bus_a.o_bus_addr,     32'h104);
    check_eq("mmio_wr_size",   32'(bus_a.o_bus_size), 32'(SIZE_BYTE));
    tick(); #1;
    check_eq("mmio_wr_rsp",    32'(bus_a.o_rsp_valid), 32'h2);
    check_eq("mmio_wr_rdata",  bus_a.o_rsp_rdata,      32'h0);
    check_eq("mmio_wr_strobe_off", 32'(strb_a),        32'h0);

    // ---------------- port 1 HWORD write to 0x204: outside the MMIO window
    tick();
    bus_a.i_req_addr[1] = 32'h204; bus_a.i_req_wdata[1] = 32'h1234;
    bus_a.i_req_size[1] = SIZE_HWORD;
    bus_a.i_req_valid = 2'b10;
    #1;
    tick(); bus_a.i_req_valid = 2'b00; #1;
    check_eq("mem_wr_strobe", 32'(strb_a),           32'h8);
    check_eq("mem_wr_size",   32'(bus_a.o_bus_size), 32'(SIZE_HWORD));
    tick(); #1;
    check_eq("mem_wr_rsp",    32'(bus_a.o_rsp_valid), 32'h2);

    // ---------------- both ports valid: grants alternate 0,1,0,1
    tick();
    bus_a.i_req_we = 2'b11;
    bus_a.i_req_addr[0] = 32'h10; bus_a.i_req_size[0] = SIZE_WORD;
    bus_a.i_req_addr[1] = 32'h20; bus_a.i_req_size[1] = SIZE_WORD;
    bus_a.i_req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr_grant%0d", i), 32'(bus_a.o_req_ready), 32'(exp_g[i]));
      if (i > 0) begin
        check_eq($sformatf("rr_rsp%0d", i - 1), 32'(bus_a.o_rsp_valid), 32'(exp_g[i-1]));
      end
      tick();
      if (i == 3) bus_a.i_req_valid = 2'b00;
      #1;
      check_eq($sformatf("rr_busy%0d", i), 32'(bus_a.o_req_ready), 32'h0);
      tick(); #1;
    end
    check_eq("rr_rsp3",    32'(bus_a.o_rsp_valid), 32'h2);
    check_eq("rr_idle_rdy", 32'(bus_a.o_req_ready), 32'h0);

    // ---------------- port 0 misaligned WORD read at 0x42
    tick();
    bus_a.i_req_we[0] = 1'b0; bus_a.i_req_addr[0] = 32'h42; bus_a.i_req_size[0] = SIZE_WORD;
    bus_a.i_req_valid = 2'b01;
    #1;
    check_eq("mis_ready", 32'(bus_a.o_req_ready), 32'h1);
    tick(); bus_a.i_req_valid = 2'b00; #1;
    check_eq("mis_rsp",    32'(bus_a.o_rsp_valid), 32'h1);
    check_eq("mis_err",    32'(bus_a.o_rsp_err),   32'h1);
    check_eq("mis_rdata",  bus_a.o_rsp_rdata,      32'h0);
    check_eq("mis_strobe", 32'(strb_a),            32'h0);
    tick(); #1;
    check_eq("mis_strobe_after", 32'(strb_a),            32'h0);
    check_eq("mis_rsp_pulse",    32'(bus_a.o_rsp_valid), 32'h0);
    check_eq("mis_err_pulse",    32'(bus_a.o_rsp_err),   32'h0);

    // ---------------- latency 3: port 0 read, port 1 held off meanwhile
    tick();
    bus_b.i_bus_rdata = 32'hCAFEF00D;
    bus_b.i_req_we = 2'b00;
    bus_b.i_req_addr[0] = 32'h80; bus_b.i_req_size[0] = SIZE_WORD;
    bus_b.i_req_addr[1] = 32'h84; bus_b.i_req_size[1] = SIZE_WORD;
    bus_b.i_req_valid = 2'b01;
    #1;
    check_eq("l3_ready", 32'(bus_b.o_req_ready), 32'h1);
    tick(); bus_b.i_req_valid = 2'b10; #1;
    check_eq("l3_strobe",  32'(strb_b),            32'h4);
    check_eq("l3_stall1",  32'(bus_b.o_req_ready), 32'h0);
    tick(); #1;
    check_eq("l3_stall2",  32'(bus_b.o_req_ready), 32'h0);
    check_eq("l3_strobe_off", 32'(strb_b),         32'h0);
    check_eq("l3_rsp_n2",  32'(bus_b.o_rsp_valid), 32'h0);
    tick(); #1;
    check_eq("l3_stall3",  32'(bus_b.o_req_ready), 32'h0);
    check_eq("l3_rsp_n3",  32'(bus_b.o_rsp_valid), 32'h0);
    tick(); bus_b.i_req_valid = 2'b00; #1;
    check_eq("l3_rsp",     32'(bus_b.o_rsp_valid), 32'h1);
    check_eq("l3_rdata",   bus_b.o_rsp_rdata,      32'hCAFEF00D);
    tick(); #1;
    check_eq("l3_rsp_pulse", 32'(bus_b.o_rsp_valid), 32'h0);

    // ---------------- reset during WAIT drops the read and restores the pointer
    tick();
    bus_b.i_req_valid = 2'b01;
    #1;
    tick(); bus_b.i_req_valid = 2'b00; #1;
    check_eq("rstw_strobe", 32'(strb_b), 32'h4);
    tick(); rst = 1'b1; #1;
    tick(); rst = 1'b0; #1;
    check_eq("rstw_strobes",  32'(strb_b),            32'h0);
    check_eq("rstw_bus_addr", bus_b.o_bus_addr,       32'h0);
    check_eq("rstw_rdata",    bus_b.o_rsp_rdata,      32'h0);
    check_eq("rstw_ready",    32'(bus_b.o_req_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rstw_no_rsp%0d", i), 32'(bus_b.o_rsp_valid), 32'h0);
      tick(); #1;
    end
    bus_b.i_req_valid = 2'b11;
    #1;
    check_eq("rstw_tie_grant", 32'(bus_b.o_req_ready), 32'h1);
    tick(); bus_b.i_req_valid = 2'b00; #1;
    repeat (3) tick();
    #1;
    check_eq("rstw_tie_rsp", 32'(bus_b.o_rsp_valid), 32'h1);
    tick(); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
